sdram_image_writer: RTL and testbench

- Parametrised successor to the single-pixel ROM-to-SDRAM copier.
- Streams an IMG_WIDTH x IMG_HEIGHT image from a synchronous ROM into SDRAM at a configurable base address.
- Uses page-mode writes: one ACTIVATE per SDRAM row, back-to-back WRITEs (burst length 1), one PRECHARGE at each page break or at image end.
- Sits between the SDRAM init sequencer (init_done) and the SDRAM pins; supports re-triggered copies via start/done.

---
 rtl/sdram_image_writer.sv | 256 +++++++++++++++++++++++++
 tb/tb_sdram_image_writer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_image_writer.sv
// sdram_image_writer: streams an IMG_WIDTH x IMG_HEIGHT image from a synchronous ROM into SDRAM
// using page-mode writes (one ACTIVATE per row, back-to-back BL1 WRITEs, one PRECHARGE per page).
// Optional macro REFRESH_EN: services AUTO REFRESH requests at row boundaries only.
module sdram_image_writer #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int PIX_W      = 3,
    parameter int COL_BITS   = 8,
    parameter int ROW_BITS   = 12,
    parameter int BANK_BITS  = 2,
    parameter int BASE_ADDR  = 0,
    parameter int T_RCD      = 3,
    parameter int T_WR       = 2,
    parameter int T_RP       = 3,
    parameter int T_RFC      = 9,
    localparam int NPIX      = IMG_WIDTH * IMG_HEIGHT,
    localparam int IDX_W     = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_done,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     rom_addr,
    input  logic [PIX_W-1:0]     rom_data,
    output logic                 cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic [ROW_BITS-1:0]  addr,
    output logic [BANK_BITS-1:0] ba,
    output logic                 cke,
    output logic [15:0]          dq_out,
`ifdef REFRESH_EN
    input  logic                 refresh_req,
    output logic                 refresh_ack,
`endif
    output logic                 dq_oe
);

    localparam int LIN_W = COL_BITS + ROW_BITS + BANK_BITS;
    // Wait counters count down to zero; the entry command itself is one of the T cycles.
    localparam logic [7:0] RCD_LD = 8'((T_RCD > 1) ? T_RCD - 2 : 0);
    localparam logic [7:0] WR_LD  = 8'((T_WR  > 1) ? T_WR  - 2 : 0);
    localparam logic [7:0] RP_LD  = 8'((T_RP  > 1) ? T_RP  - 2 : 0);
    localparam logic [7:0] RFC_LD = 8'((T_RFC > 1) ? T_RFC - 2 : 0);
    // Clears A10 on WRITE so the bank stays open (no auto-precharge).
    localparam logic [ROW_BITS-1:0] NO_AP_MASK = ~(ROW_BITS'(1) << 10);
    localparam logic [IDX_W-1:0]    LAST_K     = IDX_W'(NPIX - 1);

    if (PIX_W < 1 || PIX_W > 16 || T_RCD < 1 || T_WR < 1 || T_RP < 1 || T_RFC < 1 || NPIX < 1) begin : g_bad_param
        $error("sdram_image_writer: illegal parameter set");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_ACTIVATE, S_WAIT_RCD, S_WRITE, S_WAIT_WR,
        S_PRECHARGE, S_WAIT_RP, S_DONE
`ifdef REFRESH_EN
        , S_REFRESH, S_WAIT_RFC
`endif
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     k;      // current pixel index
    logic [LIN_W-1:0]     lin;    // linear SDRAM word address of pixel k
    logic [7:0]           cnt;
    logic                 last_pix;
    logic                 page_end;
    logic                 rp_exit;
`ifdef REFRESH_EN
    logic                 fin;    // image finished; refresh exits to DONE instead of ACTIVATE
    logic                 rfc_exit;
`endif

    logic [COL_BITS-1:0]  col;
    logic [ROW_BITS-1:0]  row;
    logic [BANK_BITS-1:0] bank;

    assign col      = lin[COL_BITS-1:0];
    assign row      = lin[COL_BITS +: ROW_BITS];
    assign bank     = lin[COL_BITS+ROW_BITS +: BANK_BITS];
    assign last_pix = (k == LAST_K);
    assign page_end = &col;
    assign rp_exit  = ((state == S_PRECHARGE) && (T_RP <= 1)) || ((state == S_WAIT_RP) && (cnt == 8'd0));
`ifdef REFRESH_EN
    assign rfc_exit    = ((state == S_REFRESH) && (T_RFC <= 1)) || ((state == S_WAIT_RFC) && (cnt == 8'd0));
    assign refresh_ack = (state == S_REFRESH);
`endif
    assign cke    = 1'b1;
    assign dq_out = 16'(rom_data);

    // Sequencer: walks the pixels, tracks the SDRAM address and enforces inter-command gaps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rom_addr <= '0;
            k        <= '0;
            lin      <= '0;
            cnt      <= '0;
`ifdef REFRESH_EN
            fin      <= 1'b0;
`endif
        end else if (!init_done) begin
            // Abandon the copy; the init sequencer re-initialises the device, so no precharge.
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        k        <= '0;
                        rom_addr <= '0;
                        lin      <= LIN_W'(BASE_ADDR);
`ifdef REFRESH_EN
                        fin      <= 1'b0;
                        state    <= refresh_req ? S_REFRESH : S_ACTIVATE;
`else
                        state    <= S_ACTIVATE;
`endif
                    end
                end
                S_ACTIVATE: begin
                    if (T_RCD > 1) begin
                        state <= S_WAIT_RCD;
                        cnt   <= RCD_LD;
                    end else begin
                        state    <= S_WRITE;
                        rom_addr <= k + IDX_W'(1);
                    end
                end
                S_WAIT_RCD: begin
                    if (cnt == 8'd0) begin
                        state    <= S_WRITE;
                        rom_addr <= k + IDX_W'(1);   // prefetch: ROM[k+1] lands in the next WRITE
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_WRITE: begin
                    if (page_end || last_pix) begin
                        if (T_WR > 1) begin
                            state <= S_WAIT_WR;
                            cnt   <= WR_LD;
                        end else begin
                            state <= S_PRECHARGE;
                        end
                    end else begin
                        k        <= k + IDX_W'(1);
                        lin      <= lin + LIN_W'(1);
                        rom_addr <= rom_addr + IDX_W'(1);
                    end
                end
                S_WAIT_WR: begin
                    if (cnt == 8'd0) state <= S_PRECHARGE;
                    else             cnt   <= cnt - 8'd1;
                end
                S_PRECHARGE, S_WAIT_RP: begin
                    if (rp_exit) begin
                        // Row boundary: advance to the first pixel of the next page.
                        if (!last_pix) begin
                            k        <= k + IDX_W'(1);
                            lin      <= lin + LIN_W'(1);
                            rom_addr <= k + IDX_W'(1);
                        end
`ifdef REFRESH_EN
                        fin <= last_pix;
                        if (refresh_req) begin
                            state <= S_REFRESH;
                        end else
`endif
                        if (last_pix) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ACTIVATE;
                        end
                    end else if (state == S_PRECHARGE) begin
                        state <= S_WAIT_RP;
                        cnt   <= RP_LD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`ifdef REFRESH_EN
                S_REFRESH, S_WAIT_RFC: begin
                    if (rfc_exit) begin
                        if (fin) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ACTIVATE;
                        end
                    end else if (state == S_REFRESH) begin
                        state <= S_WAIT_RFC;
                        cnt   <= RFC_LD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // SDRAM command decode from the registered state; anything not listed is a NOP
    always_comb begin
        cs_n  = 1'b1;
        ras_n = 1'b1;
        cas_n = 1'b1;
        we_n  = 1'b1;
        addr  = '0;
        ba    = '0;
        dq_oe = 1'b0;
        case (state)
            S_ACTIVATE: begin
                cs_n  = 1'b0;
                ras_n = 1'b0;
                addr  = row;
                ba    = bank;
            end
            S_WRITE: begin
                cs_n  = 1'b0;
                cas_n = 1'b0;
                we_n  = 1'b0;
                addr  = ROW_BITS'(col) & NO_AP_MASK;
                ba    = bank;
                dq_oe = 1'b1;
            end
            S_PRECHARGE: begin
                // addr stays zero: A10 low selects single-bank precharge
                cs_n  = 1'b0;
                ras_n = 1'b0;
                we_n  = 1'b0;
                ba    = bank;
            end
`ifdef REFRESH_EN
            S_REFRESH: begin
                cs_n  = 1'b0;
                ras_n = 1'b0;
                cas_n = 1'b0;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_image_writer.sv
// Bench for sdram_image_writer: two instances (BASE_ADDR 0 and 14) of an 8x4 image, COL_BITS=4.
// A negedge monitor logs every SDRAM command; directed tables give the expected command trace.
// Covers reset, page breaks, timing gaps, ROM data path, start handling, rst/init_done aborts.
module tb_sdram_image_writer;

    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, init_done, start;
    logic        busy [2];
    logic        done [2];
    logic [4:0]  rom_addr [2];
    logic [2:0]  rom_data [2];
    logic        cs_n [2];
    logic        ras_n [2];
    logic        cas_n [2];
    logic        we_n [2];
    logic [11:0] addr [2];
    logic [1:0]  ba [2];
    logic        cke [2];
    logic [15:0] dq_out [2];
    logic        dq_oe [2];
`ifdef REFRESH_EN
    logic        refresh_req;
    logic        refresh_ack [2];
`endif

    sdram_image_writer #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .PIX_W(3), .COL_BITS(4), .ROW_BITS(12),
        .BANK_BITS(2), .BASE_ADDR(0), .T_RCD(3), .T_WR(2), .T_RP(3), .T_RFC(9)) u_dut0 (
        .clk(clk), .rst(rst), .init_done(init_done), .start(start), .busy(busy[0]), .done(done[0]),
        .rom_addr(rom_addr[0]), .rom_data(rom_data[0]), .cs_n(cs_n[0]), .ras_n(ras_n[0]),
        .cas_n(cas_n[0]), .we_n(we_n[0]), .addr(addr[0]), .ba(ba[0]), .cke(cke[0]),
        .dq_out(dq_out[0]),
`ifdef REFRESH_EN
        .refresh_req(refresh_req), .refresh_ack(refresh_ack[0]),
`endif
        .dq_oe(dq_oe[0]));

    sdram_image_writer #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .PIX_W(3), .COL_BITS(4), .ROW_BITS(12),
        .BANK_BITS(2), .BASE_ADDR(14), .T_RCD(3), .T_WR(2), .T_RP(3), .T_RFC(9)) u_dut14 (
        .clk(clk), .rst(rst), .init_done(init_done), .start(start), .busy(busy[1]), .done(done[1]),
        .rom_addr(rom_addr[1]), .rom_data(rom_data[1]), .cs_n(cs_n[1]), .ras_n(ras_n[1]),
        .cas_n(cas_n[1]), .we_n(we_n[1]), .addr(addr[1]), .ba(ba[1]), .cke(cke[1]),
        .dq_out(dq_out[1]),
`ifdef REFRESH_EN
        .refresh_req(refresh_req), .refresh_ack(refresh_ack[1]),
`endif
        .dq_oe(dq_oe[1]));

    // Synchronous ROM: ROM[k] = k[2:0]
    always @(posedge clk) begin
        rom_data[0] <= rom_addr[0][2:0];
        rom_data[1] <= rom_addr[1][2:0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Command log
    logic log_clr = 1'b0;
    int   act_cnt [2], wr_cnt [2], pre_cnt [2], ref_cnt [2], ack_cnt [2], oe_bad [2];
    int   act_row [2][8], act_cyc [2][8], act_wr [2][8], act_ba [2][8], pre_cyc [2][8];
    int   wr_col [2][64], wr_dat [2][64], wr_cyc [2][64];
    int   ref_cyc [2], done_cyc [2];
    logic done_prev [2];

    function automatic logic [3:0] cmd_of(input int g);
        return {cs_n[g], ras_n[g], cas_n[g], we_n[g]};
    endfunction

    // Sample outputs mid-cycle and record each SDRAM command with its cycle number
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (log_clr) begin
                act_cnt[g] = 0; wr_cnt[g] = 0; pre_cnt[g] = 0; ref_cnt[g] = 0;
                ack_cnt[g] = 0; oe_bad[g] = 0; ref_cyc[g] = -1; done_cyc[g] = -1;
            end else begin
                if (cmd_of(g) == CMD_ACT && act_cnt[g] < 8) begin
                    act_row[g][act_cnt[g]] = int'(addr[g]);
                    act_ba[g][act_cnt[g]]  = int'(ba[g]);
                    act_cyc[g][act_cnt[g]] = cyc;
                    act_wr[g][act_cnt[g]]  = wr_cnt[g];
                    act_cnt[g]++;
                end
                if (cmd_of(g) == CMD_WR && wr_cnt[g] < 64) begin
                    wr_col[g][wr_cnt[g]] = int'(addr[g]);
                    wr_dat[g][wr_cnt[g]] = int'(dq_out[g]);
                    wr_cyc[g][wr_cnt[g]] = cyc;
                    wr_cnt[g]++;
                end
                if (cmd_of(g) == CMD_PRE && pre_cnt[g] < 8) begin
                    pre_cyc[g][pre_cnt[g]] = cyc;
                    pre_cnt[g]++;
                end
                if (cmd_of(g) == CMD_REF) begin
                    if (ref_cnt[g] == 0) ref_cyc[g] = cyc;
                    ref_cnt[g]++;
                end
`ifdef REFRESH_EN
                if (refresh_ack[g]) ack_cnt[g]++;
`endif
                if (dq_oe[g] != (cmd_of(g) == CMD_WR)) oe_bad[g]++;
                if (done[g] && !done_prev[g]) done_cyc[g] = cyc;
            end
            done_prev[g] = done[g];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        @(posedge clk); #1;
        log_clr = 1'b1;
        @(negedge clk); #1;
        log_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(done[0] && done[1]) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, longint'(done[0] && done[1]), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Compare one instance's logged copy against its hand-written page table
    task automatic verify_copy(input int g, input string tag);
        int np, base, lw;
        int rows [3];
        int wb [3];
        if (g == 0) begin
            np = 2; base = 0;  rows = '{0, 1, 0}; wb = '{0, 16, 32};
        end else begin
            np = 3; base = 14; rows = '{0, 1, 2}; wb = '{0, 2, 18};
        end
        check($sformatf("%s_g%0d_acts", tag, g), act_cnt[g], np);
        check($sformatf("%s_g%0d_pres", tag, g), pre_cnt[g], np);
        check($sformatf("%s_g%0d_writes", tag, g), wr_cnt[g], 32);
        check($sformatf("%s_g%0d_oe_bad", tag, g), oe_bad[g], 0);
        for (int p = 0; p < np; p++) begin
            lw = (p == np - 1) ? 31 : wb[p+1] - 1;
            check($sformatf("%s_g%0d_row%0d", tag, g, p), act_row[g][p], rows[p]);
            check($sformatf("%s_g%0d_ba%0d", tag, g, p), act_ba[g][p], 0);
            check($sformatf("%s_g%0d_pgstart%0d", tag, g, p), act_wr[g][p], wb[p]);
            check($sformatf("%s_g%0d_trcd%0d", tag, g, p), wr_cyc[g][wb[p]] - act_cyc[g][p], 3);
            check($sformatf("%s_g%0d_b2b%0d", tag, g, p), wr_cyc[g][lw] - wr_cyc[g][wb[p]], lw - wb[p]);
            check($sformatf("%s_g%0d_twr%0d", tag, g, p), pre_cyc[g][p] - wr_cyc[g][lw], 2);
            if (p > 0)
                check($sformatf("%s_g%0d_trp%0d", tag, g, p), act_cyc[g][p] - pre_cyc[g][p-1], 3);
        end
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s_g%0d_col%0d", tag, g, i), wr_col[g][i], (base + i) % 16);
            check($sformatf("%s_g%0d_dq%0d", tag, g, i), wr_dat[g][i], i % 8);
        end
        check($sformatf("%s_g%0d_done_gap", tag, g), done_cyc[g] - pre_cyc[g][np-1], 3);
        check($sformatf("%s_g%0d_busy_end", tag, g), busy[g], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, w0;
        rst = 1'b1; init_done = 1'b0; start = 1'b0;
`ifdef REFRESH_EN
        refresh_req = 1'b0;
`endif
        #12;
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_rom_addr", rom_addr[0], 0);
        check("rst_cmd", cmd_of(0), 4'b1111);
        check("rst_addr", addr[0], 0);
        check("rst_ba", ba[0], 0);
        check("rst_dq_oe", dq_oe[0], 0);
        check("rst_cke", cke[0], 1);
        @(posedge clk); #1;
        rst = 1'b0; init_done = 1'b1;

        // First copy, with a start pulse mid-copy that must be ignored
        clear_logs();
        pulse_start();
        check("start_busy", busy[0], 1);
        repeat (20) @(posedge clk);
        pulse_start();
        wait_done("copy1_done");
        verify_copy(0, "c1");
        verify_copy(1, "c1");

        // Re-trigger after done
        clear_logs();
        pulse_start();
        check("restart_done_clr", done[0], 0);
        check("restart_busy", busy[0], 1);
        wait_done("copy2_done");
        verify_copy(0, "c2");
        verify_copy(1, "c2");

        // Asynchronous reset in the middle of a WRITE
        clear_logs();
        pulse_start();
        n = 0;
        while (!(cs_n[0] == 1'b0 && cas_n[0] == 1'b0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_wr_seen", cmd_of(0), CMD_WR);
        #2 rst = 1'b1;
        #1;
        check("arst_cmd", cmd_of(0), 4'b1111);
        check("arst_busy", busy[0], 0);
        check("arst_dq_oe", dq_oe[0], 0);
        check("arst_addr", addr[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // init_done dropped mid-page
        clear_logs();
        pulse_start();
        n = 0;
        while (wr_cnt[0] < 5 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ido_wr_seen", wr_cnt[0], 5);
        w0 = wr_cnt[0];
        init_done = 1'b0;
        @(posedge clk); #1;
        check("ido_cmd", cmd_of(0), 4'b1111);
        check("ido_busy", busy[0], 0);
        check("ido_dq_oe", dq_oe[0], 0);
        repeat (20) @(posedge clk);
        #1;
        check("ido_writes", wr_cnt[0], w0 + 1);
        check("ido_no_pre", pre_cnt[0], 0);
        check("ido_done", done[0], 0);
        init_done = 1'b1;
        repeat (2) @(posedge clk);

`ifdef REFRESH_EN
        // Refresh requested during row 0 is taken only at the row boundary
        clear_logs();
        pulse_start();
        n = 0;
        while (act_cnt[0] < 1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        refresh_req = 1'b1;
        n = 0;
        while (!refresh_ack[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ref_ack_seen", refresh_ack[0], 1);
        refresh_req = 1'b0;
        wait_done("ref_copy_done");
        check("ref_cnt", ref_cnt[0], 1);
        check("ref_ack_cnt", ack_cnt[0], 1);
        check("ref_after_pre", ref_cyc[0] - pre_cyc[0][0], 3);
        check("ref_to_act", act_cyc[0][1] - ref_cyc[0], 9);
        check("ref_act_row", act_row[0][1], 1);
        check("ref_writes", wr_cnt[0], 32);
        check("ref_acts", act_cnt[0], 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
